// File: rtl/conv_result_reader.sv
// Read-side master for the convolution result register file: sweeps all result addresses
// and streams words over valid/ready. Optional ReLU at capture when CONV_READER_RELU_EN is defined.
module conv_result_reader #(
    parameter int NUM_RESULTS = 676,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] ReadReg,
    input  logic [DATA_W-1:0] ReadData,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  issue_addr;
    logic [ADDR_W-1:0]  last_addr;
    logic               cap_vld;
    logic               cap_last;
    logic [DATA_W-1:0]  buf_data [2];
    logic               buf_last [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               pop;
    logic               issue;
    logic               issue_is_last;
    logic [2:0]         occupancy;

    function automatic logic [DATA_W-1:0] capture_word(input logic [DATA_W-1:0] w);
`ifdef CONV_READER_RELU_EN
        return w[DATA_W-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    assign pop           = (count != 2'd0) && out_ready;
    // A same-cycle pop frees a slot, which keeps one word per cycle with only two entries.
    assign occupancy     = 3'(cap_vld) + 3'(count) - 3'(pop);
    assign issue_is_last = (issue_addr == ADDR_W'(NUM_RESULTS - 1));

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                // Address 0 is already on ReadReg in IDLE, so the start cycle is the first issue.
                if (start) begin
                    issue     = 1'b1;
                    state_nxt = issue_is_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (occupancy < 3'd2) begin
                    issue = 1'b1;
                    if (issue_is_last) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && buf_last[rd_ptr]) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A stalled cycle re-presents the last issued address rather than advancing.
    assign ReadReg = issue ? issue_addr : last_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            issue_addr <= '0;
            last_addr  <= '0;
            cap_vld    <= 1'b0;
            cap_last   <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            state    <= state_nxt;
            cap_vld  <= issue;
            cap_last <= issue && issue_is_last;
            if (issue) begin
                last_addr <= issue_addr;
                if (!issue_is_last) issue_addr <= issue_addr + ADDR_W'(1);
            end
            if (state == DONE) begin
                issue_addr <= '0;
                last_addr  <= '0;
            end
            if (cap_vld) begin
                buf_data[wr_ptr] <= capture_word(ReadData);
                buf_last[wr_ptr] <= cap_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(cap_vld) - 2'(pop);
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_data  = buf_data[rd_ptr];
    assign out_last  = out_valid && buf_last[rd_ptr];
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);

endmodule
